ldr_stream_bridge: RTL and testbench

LDR_STREAM_BRIDGE -- requirements
Module: ldr_stream_bridge

---
 rtl/ldr_stream_bridge.sv | 136 +++++++++++++
 tb/tb_ldr_stream_bridge.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldr_stream_bridge.sv
// HPS ioctl download -> core loader bus bridge with a small byte FIFO and a level write handshake.
// Optional LDR_STREAM_CHECKSUM_EN adds ldr_sum, the running sum of bytes handed to the core.
module ldr_stream_bridge #(
  parameter int          DEPTH = 4,
  parameter logic [7:0]  INDEX = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [19:0] ldr_addr,
  output logic [7:0]  ldr_wdat,
  output logic        ldr_oe,
  output logic        ldr_wr,
  input  logic        ldr_ack,
  output logic        ldr_done,
  output logic        ldr_err
`ifdef LDR_STREAM_CHECKSUM_EN
  ,
  output logic [15:0] ldr_sum
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for a download aimed at INDEX
  // S_LOAD  | download active, bytes pushed into the FIFO
  // S_DRAIN | download ended, FIFO emptying to the core
  // S_DONE  | load complete, held until reset
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  state_t        state_q, state_d;
  logic          dl_q;
  logic [27:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          wr_q, err_q;
  logic [19:0]   addr_q;
  logic [7:0]    wdat_q;

  logic dl_rise, dl_fall, full, empty, addr_ok, strobe_ok, push, drop, pop;

  always_comb begin
    dl_rise   = ioctl_download & ~dl_q;
    dl_fall   = ~ioctl_download & dl_q;
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    addr_ok   = (ioctl_addr[24:20] == 5'd0);
    strobe_ok = (state_q == S_LOAD) & ioctl_wr;
    push      = strobe_ok & addr_ok & ~full;
    drop      = strobe_ok & (~addr_ok | full);
    // A new write only starts once the previous ack has been released.
    pop       = ~wr_q & ~ldr_ack & ~empty;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dl_rise && ioctl_index == INDEX) state_d = S_LOAD;
      S_LOAD:  if (dl_fall) state_d = S_DRAIN;
      S_DRAIN: if (empty && !wr_q && !ldr_ack) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
    end else begin
      dl_q    <= ioctl_download;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (drop) err_q <= 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        addr_q   <= mem_q[rd_ptr_q][27:8];
        wdat_q   <= mem_q[rd_ptr_q][7:0];
        wr_q     <= 1'b1;
      end else if (ldr_ack) begin
        wr_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= {ioctl_addr[19:0], ioctl_dout};
  end

`ifdef LDR_STREAM_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)  sum_q <= '0;
    else if (pop)  sum_q <= sum_q + 16'(mem_q[rd_ptr_q][7:0]);
  end

  assign ldr_sum = sum_q;
`endif

  assign ioctl_wait = (count_q >= CW'(DEPTH - 1));
  assign ldr_addr   = addr_q;
  assign ldr_wdat   = wdat_q;
  assign ldr_wr     = wr_q;
  assign ldr_err    = err_q;
  assign ldr_oe     = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign ldr_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_ldr_stream_bridge.sv
// Randomized and directed bench for ldr_stream_bridge against a queue-based model of delivered bytes.
module tb_ldr_stream_bridge;
  localparam int DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        ioctl_wait;
  logic [19:0] ldr_addr;
  logic [7:0]  ldr_wdat;
  logic        ldr_oe;
  logic        ldr_wr;
  logic        ldr_ack = 1'b0;
  logic        ldr_done;
  logic        ldr_err;
`ifdef LDR_STREAM_CHECKSUM_EN
  logic [15:0] ldr_sum;
`endif

  ldr_stream_bridge #(.DEPTH(DEPTH), .INDEX(8'h00)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ldr_addr       (ldr_addr),
    .ldr_wdat       (ldr_wdat),
    .ldr_oe         (ldr_oe),
    .ldr_wr         (ldr_wr),
    .ldr_ack        (ldr_ack),
    .ldr_done       (ldr_done),
    .ldr_err        (ldr_err)
`ifdef LDR_STREAM_CHECKSUM_EN
    ,
    .ldr_sum        (ldr_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int          checks = 0;
  int          errors = 0;
  logic [27:0] exp_q[$];
  logic [27:0] e, held;
  logic [15:0] sum_model;
  int          wr_pulses;
  bit          ack_auto = 1'b0;
  bit          ack_force = 1'b0;
  logic        prev_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core-side responder: ack echoes ldr_wr one cycle later, or a forced level.
  initial forever begin
    @(posedge clk_sys); #1;
    ldr_ack = ack_auto ? ldr_wr : ack_force;
  end

  // Every rising ldr_wr must deliver the oldest outstanding accepted byte.
  initial begin
    prev_wr = 1'b0; sum_model = '0; wr_pulses = 0; held = '0;
    forever begin
      @(posedge clk_sys); #1;
      if (!reset_n) begin
        sum_model = '0; wr_pulses = 0;
      end else if (ldr_wr && !prev_wr) begin
        wr_pulses++;
        if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("ldr_addr", 32'(ldr_addr), 32'(e[27:8]));
          chk("ldr_wdat", 32'(ldr_wdat), 32'(e[7:0]));
          sum_model = sum_model + 16'(e[7:0]);
          held = {ldr_addr, ldr_wdat};
        end
      end else if (ldr_wr && prev_wr) begin
        chk("hold_stable", 32'({ldr_addr, ldr_wdat}), 32'(held));
      end
      prev_wr = ldr_wr;
    end
  end

  task automatic do_reset();
    ack_auto = 1'b0; ack_force = 1'b0;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'h00;
    reset_n = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index = idx; ioctl_download = 1'b1;
  endtask

  task automatic stop_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
  endtask

  task automatic strobe1(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!ldr_done && n < 300) begin
      @(negedge clk_sys); n++;
    end
    chk("done_within_bound", 32'(ldr_done), 1);
  endtask

  initial begin
    logic [24:0] a;
    logic [7:0]  d;
    bit          exp_err;
    int          accepted, n;

    // reset values, sampled while reset is held and just after release
    #1 reset_n = 1'b0;
    #2;
    chk("rst_wr", 32'(ldr_wr), 0);
    chk("rst_oe", 32'(ldr_oe), 0);
    chk("rst_done", 32'(ldr_done), 0);
    chk("rst_err", 32'(ldr_err), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_addr_dat", 32'({ldr_addr, ldr_wdat}), 0);
    do_reset();
    chk("post_rst_wait", 32'(ioctl_wait), 0);
    chk("post_rst_oe", 32'(ldr_oe), 0);

    // foreign index is ignored entirely
    start_dl(8'h01);
    strobe1(25'h0, 8'h5A);
    strobe1(25'h1, 8'hA5);
    chk("idx1_oe", 32'(ldr_oe), 0);
    stop_dl();
    repeat (4) @(negedge clk_sys);
    chk("idx1_done", 32'(ldr_done), 0);
    chk("idx1_err", 32'(ldr_err), 0);
    chk("idx1_pulses", 32'(wr_pulses), 0);

    // basic three-byte load, still from IDLE
    ack_auto = 1'b1;
    start_dl(8'h00);
    strobe1(25'h0, 8'h11); exp_q.push_back({20'h0, 8'h11});
    strobe1(25'h1, 8'h22); exp_q.push_back({20'h1, 8'h22});
    strobe1(25'h2, 8'h33); exp_q.push_back({20'h2, 8'h33});
    chk("load_oe", 32'(ldr_oe), 1);
    stop_dl();
    wait_done();
    chk("basic_pulses", 32'(wr_pulses), 3);
    chk("basic_err", 32'(ldr_err), 0);
    chk("basic_left", 32'(exp_q.size()), 0);
    chk("done_oe", 32'(ldr_oe), 0);
`ifdef LDR_STREAM_CHECKSUM_EN
    chk("basic_sum", 32'(ldr_sum), 32'h66);
`endif
    // DONE is sticky: a new download is ignored
    start_dl(8'h00);
    strobe1(25'h5, 8'h77);
    stop_dl();
    repeat (4) @(negedge clk_sys);
    chk("sticky_done", 32'(ldr_done), 1);
    chk("sticky_pulses", 32'(wr_pulses), 3);

    // out-of-range address is dropped
    do_reset();
    ack_auto = 1'b1;
    start_dl(8'h00);
    strobe1(25'h100000, 8'hAB);
    chk("range_err", 32'(ldr_err), 1);
    repeat (3) @(negedge clk_sys);
    chk("range_no_wr", 32'(ldr_wr), 0);
    chk("range_pulses", 32'(wr_pulses), 0);

    // overfill with ack held low: one byte sits on the bus, DEPTH in the FIFO
    do_reset();
    start_dl(8'h00);
    for (int k = 1; k <= DEPTH + 2; k++) begin
      d = 8'(8'h40 + k);
      strobe1(25'(k), d);
      if (k <= DEPTH + 1) exp_q.push_back({20'(k), d});
      chk($sformatf("full_wait_%0d", k), 32'(ioctl_wait), 32'(k >= DEPTH));
      chk($sformatf("full_err_%0d", k), 32'(ldr_err), 32'(k >= DEPTH + 2));
    end
    ack_auto = 1'b1;
    stop_dl();
    wait_done();
    chk("full_pulses", 32'(wr_pulses), DEPTH + 1);
    chk("full_left", 32'(exp_q.size()), 0);

    // randomized load honouring ioctl_wait
    do_reset();
    ack_auto = 1'b1;
    exp_err = 1'b0; accepted = 0;
    start_dl(8'h00);
    for (int i = 0; i < 60; i++) begin
      n = 0;
      while (ioctl_wait && n < 100) begin
        @(negedge clk_sys); n++;
      end
      if (ioctl_wait) chk("wait_release", 32'(ioctl_wait), 0);
      if ($urandom_range(0, 7) == 0) a = {5'($urandom_range(1, 31)), 20'($urandom)};
      else                           a = {5'd0, 20'($urandom)};
      d = 8'($urandom);
      strobe1(a, d);
      if (a[24:20] == 5'd0) begin
        exp_q.push_back({a[19:0], d}); accepted++;
      end else exp_err = 1'b1;
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    end
    chk("rand_oe", 32'(ldr_oe), 1);
    stop_dl();
    wait_done();
    chk("rand_pulses", 32'(wr_pulses), 32'(accepted));
    chk("rand_err", 32'(ldr_err), 32'(exp_err));
    chk("rand_left", 32'(exp_q.size()), 0);
`ifdef LDR_STREAM_CHECKSUM_EN
    chk("rand_sum", 32'(ldr_sum), 32'(sum_model));
    do_reset();
    ack_auto = 1'b1;
    start_dl(8'h00);
    strobe1(25'h0, 8'hFF); exp_q.push_back({20'h0, 8'hFF});
    strobe1(25'h1, 8'h02); exp_q.push_back({20'h1, 8'h02});
    stop_dl();
    wait_done();
    chk("sum_ff_02", 32'(ldr_sum), 32'h0101);
`endif

    // reset in the middle of a write with bytes queued, then a stale ack
    do_reset();
    start_dl(8'h00);
    strobe1(25'h10, 8'hC1); exp_q.push_back({20'h10, 8'hC1});
    strobe1(25'h11, 8'hC2);
    strobe1(25'h12, 8'hC3);
    @(negedge clk_sys);
    chk("mid_wr", 32'(ldr_wr), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(ldr_wr), 0);
    chk("mid_rst_oe", 32'(ldr_oe), 0);
    chk("mid_rst_wait", 32'(ioctl_wait), 0);
    chk("mid_rst_addr_dat", 32'({ldr_addr, ldr_wdat}), 0);
    exp_q.delete();
    ioctl_download = 1'b0;
    ack_force = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      chk("stale_ack_wr", 32'(ldr_wr), 0);
    end
    ack_force = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      chk("after_ack_wr", 32'(ldr_wr), 0);
    end
    chk("after_rst_oe", 32'(ldr_oe), 0);
    chk("after_rst_pulses", 32'(wr_pulses), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
